bombe_sweep_sequencer: RTL and testbench
========================================

# bombe_sweep_sequencer

Clocked controller that sequences the bombe deduction datapath: loads three crib characters into the datapath's ascii registers, sweeps the rotor offset 0..ROTOR_MAX one candidate per step tick, samples the match flag after a settle delay, and latches the winning offset or the error value. It replaces key-hold wait states with a valid strobe and Moore-style datapath controls, and adds abort, settle timing and result handshaking.

## Interface
- ROTOR_MAX, default 25: last rotor offset tried; rotor_value compared against it.
- SETTLE_CYCLES, default 1, legal 1..15: cycles between rotor_load/rotor_inc and match sampling.
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- char_in  in  8  ASCII crib character.
- char_valid  in  1  single-cycle strobe qualifying char_in.
- start  in  1  begin (or re-run) a sweep.
- abort  in  1  cancel and flush; highest priority after reset.
- step_tick  in  1  rate enable from the rotor-rate divider; not queued.
- rotor_value  in  8  current rotor offset from the datapath.
- match  in  1  datapath equality result (all three cribs decrypt to A,B,C).
- load_s0, load_s1, load_s2  out  1 each  single-cycle crib register loads.
- dp_reset  out  1  datapath register clear.
- rotor_load  out  1  load rotor to 0.
- rotor_inc  out  1  single-cycle rotor increment.
- result  out  8  winning offset, or 8'hFF on exhaustion.
- result_valid  out  1  high while in DONE.
- busy  out  1  high in CLEAR, SETTLE, CHECK, STEP.
- crib_count  out  2  characters accepted (0..3).
- state_out  out  4  current state encoding, for debug LEDs.

## Operation
- States: FLUSH, IDLE, READY, CLEAR, SETTLE, CHECK, STEP, DONE.
- FLUSH: dp_reset=1, crib_count<=0; next IDLE.
- IDLE: char_valid with char_in in 65..90 asserts load_s{crib_count} in the same cycle (combinational on char_valid) and increments crib_count; at crib_count==3 go READY. Non-uppercase chars ignored. start ignored.
- READY: start -> CLEAR. char_valid ignored.
- CLEAR: rotor_load=1; load settle counter with SETTLE_CYCLES; next SETTLE.
- SETTLE: decrement counter; at 1 go CHECK.
- CHECK: match -> DONE, result<=rotor_value. Else rotor_value==ROTOR_MAX -> DONE, result<=8'hFF. Else -> STEP.
- STEP: wait for step_tick; rotor_inc = step_tick in this state only; on tick reload settle counter, go SETTLE.
- DONE: hold result; start -> CLEAR (same cribs retained).
- abort in any state except FLUSH -> FLUSH; result_valid drops, result held.
- Priority: reset > abort > start > char_valid. step_tick outside STEP is dropped.

## Timing
- Reset values: state FLUSH, result 8'h00, crib_count 0, all strobes 0. dp_reset is therefore high the cycle after reset deasserts.
- Registered state. Strobes decode from state, except load_sN and rotor_inc, which also gate on char_valid/step_tick.
- start sampled in cycle 0 -> CLEAR in cycle 1 -> CHECK in cycle 2+SETTLE_CYCLES. A match at offset 0 gives result_valid in cycle 3+SETTLE_CYCLES.
- Each further candidate costs tick wait + 1 + SETTLE_CYCLES cycles.
- match is sampled only in CHECK; glitches elsewhere are ignored.

## Configuration
- BOMBE_SWEEP_CONTINUE_EN defined: start in DONE after a match with rotor_value<ROTOR_MAX goes to STEP, resuming at offset+1 to find the next solution. After exhaustion (8'hFF), start restarts via CLEAR.
- Not defined: start in DONE always restarts via CLEAR from offset 0.

## Structure
- Shared package bombe_pkg holds:
  - ORD_A=65, ORD_Z=90, ERROR_VAL=8'hFF, default ROTOR_MAX;
  - state typedef with fixed 4-bit encodings for state_out.
- One sub-module: bombe_settle_timer, a 4-bit loadable down-counter with a done flag.

## Test plan
- Reset, then 'Q','R','S' strobes -> load_s0/1/2 one cycle each, crib_count 3, state READY; dp_reset seen once after reset.
- Cribs 'A','B','C', start, tick every 4 cycles, SETTLE_CYCLES=1 -> rotor_load once, match at 0, result=0, result_valid at cycle 4 after start.
- Cribs 'D','E','F' (match at offset 3) -> exactly 3 rotor_inc pulses, result=3.
- Cribs never matching -> 25 rotor_inc pulses, result=8'hFF at rotor_value 25.
- abort during STEP at offset 10 -> FLUSH next cycle, dp_reset 1 cycle, crib_count 0, no further rotor_inc.
- Char '7' in IDLE -> no load strobe, crib_count unchanged. start and abort in the same cycle in READY -> FLUSH.

Source files
------------

// File: rtl/bombe_pkg.sv
// Shared constants and state encoding for the bombe sweep sequencer.
// State codes are fixed because they drive the debug LEDs.
package bombe_pkg;

  localparam logic [7:0] ORD_A = 8'd65;
  localparam logic [7:0] ORD_Z = 8'd90;
  localparam logic [7:0] ERROR_VAL = 8'hFF;
  localparam int unsigned ROTOR_MAX_DEF = 25;

  typedef enum logic [3:0] {
    S_FLUSH  = 4'd0,
    S_IDLE   = 4'd1,
    S_READY  = 4'd2,
    S_CLEAR  = 4'd3,
    S_SETTLE = 4'd4,
    S_CHECK  = 4'd5,
    S_STEP   = 4'd6,
    S_DONE   = 4'd7
  } state_e;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ORD_A) && (c <= ORD_Z);
  endfunction

endpackage

// File: rtl/bombe_settle_timer.sv
// Loadable 4-bit down-counter; done marks the last settle cycle.
// Holds at zero rather than wrapping when decremented past the end.
module bombe_settle_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] val_i,
  input  logic       dec_i,
  output logic       done_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i && (cnt_q != 4'd0))
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/bombe_sweep_sequencer.sv
// Crib loader and rotor sweep controller for the bombe datapath.
// Optional macro BOMBE_SWEEP_CONTINUE_EN: start in DONE resumes after a hit.
module bombe_sweep_sequencer
  import bombe_pkg::*;
#(
  parameter int unsigned ROTOR_MAX     = ROTOR_MAX_DEF,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       start,
  input  logic       abort,
  input  logic       step_tick,
  input  logic [7:0] rotor_value,
  input  logic       match,
  output logic       load_s0,
  output logic       load_s1,
  output logic       load_s2,
  output logic       dp_reset,
  output logic       rotor_load,
  output logic       rotor_inc,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic [1:0] crib_count,
  output logic [3:0] state_out
);

  localparam logic [7:0] RMAX  = 8'(ROTOR_MAX);
  localparam logic [3:0] SLOAD = 4'(SETTLE_CYCLES);

  state_e     state_q;
  logic [7:0] result_q;
  logic [1:0] crib_q;
  logic       tmr_done;
  logic       char_acc;
  logic       tick_acc;
`ifdef BOMBE_SWEEP_CONTINUE_EN
  logic       found_q;
`endif

  assign char_acc = (state_q == S_IDLE) && char_valid
                  && is_upper(char_in) && !abort && !reset;
  assign tick_acc = (state_q == S_STEP) && step_tick
                  && !abort && !reset;

  bombe_settle_timer u_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i ((state_q == S_CLEAR) || tick_acc),
    .val_i  (SLOAD),
    .dec_i  (state_q == S_SETTLE),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FLUSH;
      result_q <= 8'h00;
      crib_q   <= 2'd0;
`ifdef BOMBE_SWEEP_CONTINUE_EN
      found_q  <= 1'b0;
`endif
    end else if (abort && (state_q != S_FLUSH)) begin
      state_q <= S_FLUSH;
    end else begin
      unique case (state_q)
        S_FLUSH: begin
          crib_q  <= 2'd0;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (char_acc) begin
            crib_q <= crib_q + 2'd1;
            if (crib_q == 2'd2) state_q <= S_READY;
          end
        end
        S_READY:  if (start) state_q <= S_CLEAR;
        S_CLEAR:  state_q <= S_SETTLE;
        S_SETTLE: if (tmr_done) state_q <= S_CHECK;
        S_CHECK: begin
          if (match) begin
            result_q <= rotor_value;
            state_q  <= S_DONE;
`ifdef BOMBE_SWEEP_CONTINUE_EN
            found_q  <= 1'b1;
`endif
          end else if (rotor_value == RMAX) begin
            result_q <= ERROR_VAL;
            state_q  <= S_DONE;
`ifdef BOMBE_SWEEP_CONTINUE_EN
            found_q  <= 1'b0;
`endif
          end else begin
            state_q <= S_STEP;
          end
        end
        S_STEP: if (step_tick) state_q <= S_SETTLE;
        S_DONE: begin
          if (start) begin
`ifdef BOMBE_SWEEP_CONTINUE_EN
            // a hit below the top offset carries on from the next candidate
            if (found_q && (rotor_value < RMAX))
              state_q <= S_STEP;
            else
              state_q <= S_CLEAR;
`else
            state_q <= S_CLEAR;
`endif
          end
        end
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  assign load_s0      = char_acc && (crib_q == 2'd0);
  assign load_s1      = char_acc && (crib_q == 2'd1);
  assign load_s2      = char_acc && (crib_q == 2'd2);
  assign dp_reset     = (state_q == S_FLUSH);
  assign rotor_load   = (state_q == S_CLEAR);
  assign rotor_inc    = tick_acc;
  assign result       = result_q;
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q == S_CLEAR) || (state_q == S_SETTLE)
                      || (state_q == S_CHECK) || (state_q == S_STEP);
  assign crib_count   = crib_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_bombe_sweep_sequencer.sv
// Scoreboard bench: Caesar-style datapath model, expected results queued on start.
// Default build (continue feature off).
module tb_bombe_sweep_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       step_tick = 1'b0;
  logic [7:0] rot = 8'h00;
  logic       match;
  logic       load_s0, load_s1, load_s2;
  logic       dp_reset, rotor_load, rotor_inc;
  logic [7:0] result;
  logic       result_valid, busy;
  logic [1:0] crib_count;
  logic [3:0] state_out;

  logic [7:0] c0 = 8'h00, c1 = 8'h00, c2 = 8'h00;
  logic [7:0] exp_q[$];
  logic       rv_prev = 1'b0;
  int errors = 0, checks = 0;
  int n_dp = 0, n_rl = 0, n_inc = 0;
  int n_l0 = 0, n_l1 = 0, n_l2 = 0;
  int tcnt = 0;

  bombe_sweep_sequencer #(.ROTOR_MAX(25), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .char_in(char_in),
    .char_valid(char_valid), .start(start), .abort(abort),
    .step_tick(step_tick), .rotor_value(rot), .match(match),
    .load_s0(load_s0), .load_s1(load_s1), .load_s2(load_s2),
    .dp_reset(dp_reset), .rotor_load(rotor_load),
    .rotor_inc(rotor_inc), .result(result),
    .result_valid(result_valid), .busy(busy),
    .crib_count(crib_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // datapath model: match when each crib shifted back by rot gives A,B,C
  assign match = (8'(c0 - rot) == 8'd65) && (8'(c1 - rot) == 8'd66)
              && (8'(c2 - rot) == 8'd67);

  always @(posedge clk) begin
    if (dp_reset || rotor_load) rot <= 8'd0;
    else if (rotor_inc)         rot <= rot + 8'd1;
    if (load_s0) c0 <= char_in;
    if (load_s1) c1 <= char_in;
    if (load_s2) c2 <= char_in;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_off(input logic [7:0] a,
      input logic [7:0] b, input logic [7:0] c);
    for (int k = 0; k <= 25; k++)
      if (8'(a - 8'(k)) == 8'd65 && 8'(b - 8'(k)) == 8'd66
          && 8'(c - 8'(k)) == 8'd67)
        return 8'(k);
    return 8'hFF;
  endfunction

  initial forever begin
    @(posedge clk); #1;
    tcnt++;
    step_tick = (tcnt % 4 == 0);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (dp_reset)   n_dp++;
      if (rotor_load) n_rl++;
      if (rotor_inc)  n_inc++;
      if (load_s0)    n_l0++;
      if (load_s1)    n_l1++;
      if (load_s2)    n_l2++;
      if (result_valid && !rv_prev) begin
        if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else chk("sb_result", {24'd0, result}, {24'd0, exp_q.pop_front()});
      end
    end
    rv_prev = result_valid;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_char(input logic [7:0] c);
    cyc(1);
    char_in = c; char_valid = 1'b1;
    cyc(1);
    char_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    cyc(1);
    start = 1'b1;
    exp_q.push_back(model_off(a, b, c));
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!result_valid && n < 2000) begin cyc(1); n++; end
    chk(tag, {31'd0, result_valid}, 32'd1);
    @(negedge clk); #1;
  endtask

  task automatic do_abort();
    cyc(1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(2);
  endtask

  initial begin
    int snap, n;
    cyc(3);
    chk("rst_state", {28'd0, state_out}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_cribs", {30'd0, crib_count}, 32'd0);
    chk("rst_rv_busy", {30'd0, result_valid, busy}, 32'd0);
    reset = 1'b0;
    chk("dp_reset_after_rst", {31'd0, dp_reset}, 32'd1);
    cyc(1);
    chk("idle_state", {28'd0, state_out}, 32'd1);

    send_char("Q"); send_char("R"); send_char("S");
    cyc(1);
    chk("qrs_loads", n_l0 * 100 + n_l1 * 10 + n_l2, 32'd111);
    chk("qrs_cribs", {30'd0, crib_count}, 32'd3);
    chk("qrs_ready", {28'd0, state_out}, 32'd2);
    chk("dp_reset_once", n_dp, 32'd1);
    do_start("Q", "R", "S");
    wait_done("qrs_done");

    do_abort();
    n_l0 = 0; n_l1 = 0; n_l2 = 0;
    send_char("A");
    send_char("7");
    chk("digit_cribs", {30'd0, crib_count}, 32'd1);
    chk("digit_loads", n_l0 * 100 + n_l1 * 10 + n_l2, 32'd100);
    send_char("B"); send_char("C");
    cyc(1);
    n_rl = 0;
    start = 1'b1;
    exp_q.push_back(model_off("A", "B", "C"));
    cyc(1);
    start = 1'b0;
    chk("abc_clear", {28'd0, state_out}, 32'd3);
    cyc(2);
    chk("abc_no_rv_c3", {31'd0, result_valid}, 32'd0);
    cyc(1);
    chk("abc_rv_c4", {31'd0, result_valid}, 32'd1);
    @(negedge clk); #1;
    chk("abc_rotor_load", n_rl, 32'd1);

    do_abort();
    send_char("D"); send_char("E"); send_char("F");
    n_inc = 0;
    do_start("D", "E", "F");
    wait_done("def_done");
    chk("def_incs", n_inc, 32'd3);
    chk("def_result", {24'd0, result}, 32'd3);

    do_abort();
    send_char("A"); send_char("A"); send_char("A");
    n_inc = 0;
    do_start("A", "A", "A");
    wait_done("nm_done");
    chk("nm_incs", n_inc, 32'd25);
    chk("nm_result", {24'd0, result}, 32'hFF);
    chk("nm_rotor", {24'd0, rot}, 32'd25);

    do_start("A", "A", "A");
    n = 0;
    while (!(state_out == 4'd6 && rot == 8'd10) && n < 2000) begin
      cyc(1); n++;
    end
    chk("ab_reach_10", {24'd0, rot}, 32'd10);
    abort = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk); #1;
    snap = n_inc;
    n_dp = 0;
    cyc(1);
    abort = 1'b0;
    chk("ab_flush", {28'd0, state_out}, 32'd0);
    chk("ab_dp_reset", {31'd0, dp_reset}, 32'd1);
    chk("ab_rv_drop", {31'd0, result_valid}, 32'd0);
    chk("ab_result_held", {24'd0, result}, 32'hFF);
    cyc(1);
    chk("ab_cribs", {30'd0, crib_count}, 32'd0);
    cyc(20);
    chk("ab_no_inc", n_inc, snap);
    chk("ab_dp_once", n_dp, 32'd1);

    send_char("A"); send_char("B"); send_char("C");
    cyc(1);
    start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    chk("sa_flush", {28'd0, state_out}, 32'd0);
    cyc(5);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
